logic_op_pipe: RTL and testbench
================================

// Module: logic_op_pipe
// PURPOSE
//   Parametrised, pipelined bitwise logic unit: generalises the fixed 1-bit
//   f = (a&b)|~c gate network to WIDTH-bit operands with a run-time opcode.
//   Uses a valid/ready handshake on both sides and a 2-stage registered pipeline.
//   Serves as the shared logic datapath for later ALU and datapath blocks.
// PARAMETERS
//   WIDTH    8    operand/result width in bits (>=1)
//   CNT_W    16   width of the completed-transaction counter
// PORTS
//   clk        in   1       single clock; all state updates on posedge
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       operand beat valid
//   in_ready   out  1       block can accept a beat this cycle
//   in_op      in   3       opcode (see BEHAVIOUR)
//   in_a       in   WIDTH   operand A
//   in_b       in   WIDTH   operand B
//   in_c       in   WIDTH   operand C (used by AOI only)
//   out_valid  out  1       result valid
//   out_ready  in   1       downstream accepts result
//   out_y      out  WIDTH   result
//   out_cnt    out  CNT_W   number of results accepted downstream (out_valid&out_ready)
// BEHAVIOUR
//   Opcodes: 0 AND a&b | 1 OR a|b | 2 XOR a^b | 3 NAND ~(a&b) | 4 NOR ~(a|b)
//            5 XNOR ~(a^b) | 6 NOT ~a | 7 AOI (a&b)|~c. All bitwise, WIDTH bits; no carries.
//   Stage S1 registers {op result, valid}; stage S2 is the output register.
//   s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv.
//   in_ready is a combinational function of out_ready and the stage valids (no skid buffer).
//   Accept when in_valid & in_ready; result on out_y exactly 2 cycles later if never stalled.
//   Throughput 1 beat/cycle with out_ready held high; no beat lost or duplicated under stall.
//   While out_valid & !out_ready: out_y, out_valid stay stable; S1 holds if also full.
//   in_valid=0 with in_ready=1: a bubble enters S1 (s1_valid<=0); S1 data unchanged.
//   Simultaneous accept and output handshake in one cycle: both happen, pipeline stays full.
//   out_cnt increments on out_valid & out_ready; wraps 2^CNT_W-1 -> 0, no saturation.
//   Reset (any cycle, including mid-stream): s1_valid=0, out_valid=0, out_y=0, out_cnt=0;
//   in-flight beats are dropped; in_ready=1 in the first cycle after reset.
//   Data registers load only when their stage advances; valids gate all outputs.
// CONFIGURATION
//   LOGIC_REDUCE_EN defined: extra outputs out_any (|out_y), out_all (&out_y),
//     out_par (^out_y), each 1 bit, registered in S2 alongside out_y, reset to 0,
//     held stable under stall exactly like out_y.
//   Not defined: the three ports and their registers do not exist; all else identical.
// STRUCTURE
//   logic_pkg: opcode localparams OP_AND..OP_AOI (3-bit), OP_W=3.
//   Sub-module logic_op_core: purely combinational (op,a,b,c)->y, WIDTH-parametrised;
//     instantiated once ahead of S1. Pipeline, handshake and counter stay in logic_op_pipe.
// TESTING
//   1 Reset: rst=1 for 2 cycles mid-stream with 2 beats in flight -> out_valid=0,
//     out_y=0, out_cnt=0 next cycle; in_ready=1; dropped beats never appear.
//   2 Opcodes: WIDTH=8, a=8'hC5,b=8'h3A,c=8'h0F, ops 0..7, out_ready=1 -> y =
//     00,FF,FF,FF,00,00,3A,F0, each 2 cycles after accept, in order.
//   3 Backpressure: stream 10 beats, out_ready=0 for cycles 3-7 -> in_ready drops
//     once S1,S2 full; out_y stable while stalled; all 10 results delivered in order.
//   4 Throughput: 64 back-to-back random beats, out_ready=1 -> 64 results in 64
//     consecutive cycles after 2-cycle fill; out_cnt=64 at end.
//   5 Counter wrap: CNT_W=4, 17 accepted results -> out_cnt reads 15 then 0 then 1.
//   6 LOGIC_REDUCE_EN: op OR a=0,b=0 -> any=0,all=0,par=0; op NAND a=b=0 -> any=1,
//     all=1, par=0 (WIDTH=8); build without macro also compiles and passes 1-5.

Source files
------------

// File: rtl/logic_op_pipe_pkg.sv
// Opcode encodings shared by the logic pipeline, its core and its bus interface.
package logic_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OP_W-1:0] OP_AOI  = 3'd7;
endpackage

// File: rtl/logic_op_pipe_if.sv
// Operand/result bus of logic_op_pipe; LOGIC_REDUCE_EN adds the reduction outputs.
// Handshake: a beat transfers on a rising clk edge where valid & ready are both high;
// a producer holding valid high keeps its payload stable until that edge.
interface logic_op_pipe_if
  import logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [CNT_W-1:0] out_cnt;
`ifdef LOGIC_REDUCE_EN
  logic             out_any;
  logic             out_all;
  logic             out_par;
`endif

  modport master (
    output in_valid, in_op, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_y, out_cnt
`ifdef LOGIC_REDUCE_EN
    , input out_any, out_all, out_par
`endif
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_y, out_cnt
`ifdef LOGIC_REDUCE_EN
    , output out_any, out_all, out_par
`endif
  );
endinterface

// File: rtl/logic_op_pipe_core.sv
// Purely combinational bitwise logic unit: (op, a, b, c) -> y.
module logic_op_core
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_AOI:  y = (a & b) | ~c;
    endcase
  end
endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready pipelined logic unit with a completed-result counter.
// LOGIC_REDUCE_EN adds registered any/all/parity reductions of out_y.
module logic_op_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  logic_op_pipe_if.slave  bus
);
  logic             s1_valid;
  logic [WIDTH-1:0] s1_y;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_y_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] core_y;
  logic             s1_adv;
  logic             s2_adv;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op (bus.in_op),
    .a  (bus.in_a),
    .b  (bus.in_b),
    .c  (bus.in_c),
    .y  (core_y)
  );

  // No skid buffer: a stall at the output ripples straight back to in_ready.
  assign s2_adv = !out_valid_q || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_y        <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      cnt_q       <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) s1_y <= core_y;
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid;
        if (s1_valid) out_y_q <= s1_y;
      end
      if (out_valid_q && bus.out_ready) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_cnt   = cnt_q;

`ifdef LOGIC_REDUCE_EN
  logic any_q;
  logic all_q;
  logic par_q;

  // Reductions travel with out_y so they share its stall behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_q <= 1'b0;
      all_q <= 1'b0;
      par_q <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      any_q <= |s1_y;
      all_q <= &s1_y;
      par_q <= ^s1_y;
    end
  end

  assign bus.out_any = any_q;
  assign bus.out_all = all_q;
  assign bus.out_par = par_q;
`endif
endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe; LOGIC_REDUCE_EN also checks the reductions.
module tb_logic_op_pipe;
  localparam int W = 8;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] y;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic_op_pipe_if #(.WIDTH(W), .CNT_W(16)) ifc ();
  logic_op_pipe_if #(.WIDTH(W), .CNT_W(4))  ifw ();

  logic_op_pipe #(.WIDTH(W), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic_op_pipe #(.WIDTH(W), .CNT_W(4)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (ifw)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           cnt_model = 0;
  bit           chk_lat = 1'b0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] y_prev = '0;
  vec_t         tbl[10];

  function automatic logic [W-1:0] ref_y(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (op)
        3'd0: r[i] = a[i] && b[i];
        3'd1: r[i] = a[i] || b[i];
        3'd2: r[i] = a[i] != b[i];
        3'd3: r[i] = !(a[i] && b[i]);
        3'd4: r[i] = !(a[i] || b[i]);
        3'd5: r[i] = a[i] == b[i];
        3'd6: r[i] = !a[i];
        default: r[i] = (a[i] && b[i]) || !c[i];
      endcase
    end
    return r;
  endfunction

  function automatic int ones(input logic [W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] c, input bit ordy,
                      input bit use_exp, input logic [W-1:0] exp_y, output bit acc);
    logic [W-1:0] e;
    int           a0;
    int           n1;
    @(negedge clk);
    if (stall_prev) begin
      check("stall_valid", 64'(ifc.out_valid), 64'd1);
      check("stall_y", 64'(ifc.out_y), 64'(y_prev));
    end
    ifc.in_valid  = v;
    ifc.in_op     = op;
    ifc.in_a      = a;
    ifc.in_b      = b;
    ifc.in_c      = c;
    ifc.out_ready = ordy;
    #1;
    check("out_cnt", 64'(ifc.out_cnt), 64'(cnt_model[15:0]));
    acc = v && ifc.in_ready;
    if (ifc.out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_out");
      end else begin
        e  = exp_q.pop_front();
        a0 = acc_q.pop_front();
        check("out_y", 64'(ifc.out_y), 64'(e));
        if (chk_lat) check("latency", 64'(cyc - a0), 64'd2);
`ifdef LOGIC_REDUCE_EN
        n1 = ones(e);
        check("out_any", 64'(ifc.out_any), 64'(n1 > 0));
        check("out_all", 64'(ifc.out_all), 64'(n1 == W));
        check("out_par", 64'(ifc.out_par), 64'(n1 % 2));
`else
        n1 = 0;
`endif
      end
      cnt_model++;
    end
    stall_prev = ifc.out_valid && !ordy;
    y_prev     = ifc.out_y;
    if (acc) begin
      exp_q.push_back(use_exp ? exp_y : ref_y(op, a, b, c));
      acc_q.push_back(cyc);
    end
  endtask

  task automatic rnd_step(input bit v, input bit ordy, output bit acc);
    step(v, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom), W'($urandom),
         ordy, 1'b0, '0, acc);
  endtask

  task automatic drain();
    bit acc;
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      step(1'b0, 3'd0, '0, '0, '0, 1'b1, 1'b0, '0, acc);
      k++;
    end
    if (exp_q.size() > 0) fail_now("drain_timeout");
    repeat (3) step(1'b0, 3'd0, '0, '0, '0, 1'b1, 1'b0, '0, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifw.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("rst_out_y", 64'(ifc.out_y), 64'd0);
    check("rst_out_cnt", 64'(ifc.out_cnt), 64'd0);
    check("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    exp_q.delete();
    acc_q.delete();
    cnt_model  = 0;
    stall_prev = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit acc;
    bit saw_low;
    int sent;
    int nout;

    tbl[0] = '{3'd0, 8'hC5, 8'h3A, 8'h0F, 8'h00};
    tbl[1] = '{3'd1, 8'hC5, 8'h3A, 8'h0F, 8'hFF};
    tbl[2] = '{3'd2, 8'hC5, 8'h3A, 8'h0F, 8'hFF};
    tbl[3] = '{3'd3, 8'hC5, 8'h3A, 8'h0F, 8'hFF};
    tbl[4] = '{3'd4, 8'hC5, 8'h3A, 8'h0F, 8'h00};
    tbl[5] = '{3'd5, 8'hC5, 8'h3A, 8'h0F, 8'h00};
    tbl[6] = '{3'd6, 8'hC5, 8'h3A, 8'h0F, 8'h3A};
    tbl[7] = '{3'd7, 8'hC5, 8'h3A, 8'h0F, 8'hF0};
    tbl[8] = '{3'd1, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[9] = '{3'd3, 8'h00, 8'h00, 8'h00, 8'hFF};

    ifc.in_valid = 1'b0; ifc.in_op = '0; ifc.in_a = '0; ifc.in_b = '0; ifc.in_c = '0;
    ifc.out_ready = 1'b1;
    ifw.in_valid = 1'b0; ifw.in_op = '0; ifw.in_a = '0; ifw.in_b = '0; ifw.in_c = '0;
    ifw.out_ready = 1'b1;

    do_reset();

    // Reset mid-stream with two beats in flight; they must never surface.
    rnd_step(1'b1, 1'b1, acc);
    rnd_step(1'b1, 1'b1, acc);
    do_reset();
    repeat (4) step(1'b0, 3'd0, '0, '0, '0, 1'b1, 1'b0, '0, acc);
    for (int i = 0; i < 3; i++) rnd_step(1'b1, 1'b1, acc);
    drain();

    // Opcode table, fixed 2-cycle latency.
    chk_lat = 1'b1;
    for (int i = 0; i < 10; i++)
      step(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, 1'b1, 1'b1, tbl[i].y, acc);
    drain();
    chk_lat = 1'b0;

    // Backpressure: out_ready low for relative cycles 3..7.
    saw_low = 1'b0;
    sent = 0;
    for (int k = 0; k < 60 && sent < 10; k++) begin
      rnd_step(1'b1, !(k >= 3 && k <= 7), acc);
      if (!ifc.in_ready) saw_low = 1'b1;
      if (acc) sent++;
    end
    check("bp_in_ready_dropped", 64'(saw_low), 64'd1);
    check("bp_sent", 64'(sent), 64'd10);
    drain();

    // Throughput: 64 back-to-back beats.
    do_reset();
    chk_lat = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rnd_step(1'b1, 1'b1, acc);
      check("b2b_accept", 64'(acc), 64'd1);
    end
    drain();
    chk_lat = 1'b0;
    check("cnt_after_64", 64'(ifc.out_cnt), 64'd64);

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++)
      rnd_step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, acc);
    drain();

    // Counter wrap on the CNT_W=4 instance.
    do_reset();
    nout = 0;
    for (int k = 0; k < 60 && nout < 17; k++) begin
      @(negedge clk);
      ifw.in_valid  = (k < 17);
      ifw.in_op     = 3'($urandom_range(0, 7));
      ifw.in_a      = W'($urandom);
      ifw.out_ready = 1'b1;
      #1;
      check("wrap_cnt", 64'(ifw.out_cnt), 64'(nout % 16));
      if (ifw.out_valid) nout++;
    end
    ifw.in_valid = 1'b0;
    @(negedge clk);
    check("wrap_results", 64'(nout), 64'd17);
    check("wrap_final", 64'(ifw.out_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
